// File: rtl/operand_seq_pkg.sv
// Shared types and defaults for the operand sequencer and its dwell timer.
package operand_seq_pkg;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_DWELL     = 50;
    localparam int DWELL_TIMER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Load/expire down-counter. After a load of N (N >= 1), expired is high
// during the Nth cycle following the load edge, so a client that leaves on
// expired spends exactly N cycles waiting.
module dwell_timer
    import operand_seq_pkg::*;
#(
    parameter int TW = DWELL_TIMER_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    output logic          expired
);

    logic [TW-1:0] remain_reg;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            remain_reg <= '0;
        end else if (load) begin
            remain_reg <= load_value;
        end else if (remain_reg != '0) begin
            remain_reg <= remain_reg - TW'(1);
        end
    end

    // Zero also reads as expired so an idle timer can never stall a client.
    assign expired = (remain_reg <= TW'(1));

endmodule

// File: rtl/operand_sequencer.sv
// Sweeps every (x, y) operand pair in index order towards an AND stage with a
// valid/ready handshake, holding DWELL idle cycles after each accepted pair.
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DWELL = DEFAULT_DWELL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [2*WIDTH:0] count
);

    localparam int NW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;
    localparam logic [NW-1:0] LAST_INDEX = '1;
    localparam logic [DWELL_TIMER_WIDTH-1:0] DWELL_LOAD = DWELL_TIMER_WIDTH'(DWELL);

    seq_state_t       state_reg, state_next;
    logic [NW-1:0]    n_reg, n_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] x_reg, y_reg;
    logic             valid_reg, busy_reg, done_reg;
    logic             timer_load;
    logic             timer_expired;
    logic             transfer;
    logic             last_pair;

    // valid_reg is high exactly while in DRIVE, so the handshake never looks
    // at ready combinationally on the output side.
    assign transfer  = valid_reg && ready;
    assign last_pair = (n_reg == LAST_INDEX);

    dwell_timer #(
        .TW(DWELL_TIMER_WIDTH)
    ) u_dwell_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(DWELL_LOAD),
        .expired   (timer_expired)
    );

    // Next-state, pair index and accepted-pair count.
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        count_next = count_reg;
        timer_load = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    n_next     = '0;
                    count_next = '0;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (transfer) begin
                    count_next = count_reg + CW'(1);
                    if (DWELL > 0) begin
                        timer_load = 1'b1;
                        state_next = HOLD;
                    end else if (last_pair) begin
                        state_next = DONE;
                    end else begin
                        n_next = n_reg + NW'(1);
                    end
                end
            end
            HOLD: begin
                if (timer_expired) begin
                    if (last_pair) begin
                        state_next = DONE;
                    end else begin
                        n_next     = n_reg + NW'(1);
                        state_next = DRIVE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs, all derived from the next-cycle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            count_reg <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            count_reg <= count_next;
            x_reg     <= n_next[WIDTH-1:0];
            y_reg     <= n_next[NW-1:WIDTH];
            valid_reg <= (state_next == DRIVE);
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == DONE);
        end
    end

    assign x     = x_reg;
    assign y     = y_reg;
    assign valid = valid_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign count = count_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: one instance with DWELL=50, one with DWELL=0.
module tb_operand_sequencer;

    localparam int W      = 4;
    localparam int CW     = 2 * W + 1;
    localparam int NPAIRS = 1 << (2 * W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Instance A: DWELL = 50
    logic          rst_a, start_a, ready_a;
    logic [W-1:0]  x_a, y_a, z_a;
    logic          valid_a, busy_a, done_a;
    logic [CW-1:0] count_a;

    // Instance B: DWELL = 0
    logic          rst_b, start_b, ready_b;
    logic [W-1:0]  x_b, y_b;
    logic          valid_b, busy_b, done_b;
    logic [CW-1:0] count_b;

    // The downstream AND stage fed directly by instance A.
    assign z_a = x_a & y_a;

    operand_sequencer #(.WIDTH(W), .DWELL(50)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .ready(ready_a),
        .x(x_a), .y(y_a), .valid(valid_a), .busy(busy_a), .done(done_a), .count(count_a)
    );

    operand_sequencer #(.WIDTH(W), .DWELL(0)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .ready(ready_b),
        .x(x_b), .y(y_b), .valid(valid_b), .busy(busy_b), .done(done_b), .count(count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1; start_a = 0; ready_a = 0;
        rst_b = 1; start_b = 0; ready_b = 0;
        tick(); tick();
        rst_a = 0; rst_b = 0;
        checks++; if (x_a !== '0 || y_a !== '0) begin errors++; $display("FAIL reset_xy got (%0d,%0d) expected (0,0)", x_a, y_a); end
        checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_flags got v=%b b=%b d=%b expected 0 0 0", valid_a, busy_a, done_a); end
        checks++; if (count_a !== '0) begin errors++; $display("FAIL reset_count got %0d expected 0", count_a); end
        checks++; if (valid_b !== 1'b0 || busy_b !== 1'b0 || count_b !== '0) begin errors++; $display("FAIL reset_b got v=%b b=%b c=%0d expected 0 0 0", valid_b, busy_b, count_b); end
        $display("test_reset done");
    endtask

    // First four pairs at DWELL=50, accepted 51 cycles apart.
    task automatic test_first_pairs();
        int k, budget, last_cyc;
        logic [W-1:0] ex;
        k = 0; budget = 0; last_cyc = 0;
        ready_a = 1; start_a = 1; tick(); start_a = 0;
        checks++; if (busy_a !== 1'b1 || valid_a !== 1'b1) begin errors++; $display("FAIL start_drive got b=%b v=%b expected 1 1", busy_a, valid_a); end
        while (k < 4 && budget < 400) begin
            if (valid_a && ready_a) begin
                ex = W'(k);
                checks++; if (x_a !== ex || y_a !== '0) begin errors++; $display("FAIL first_pair k=%0d got (%0d,%0d) expected (%0d,0)", k, x_a, y_a, ex); end
                if (k > 0) begin
                    checks++; if (cyc - last_cyc != 51) begin errors++; $display("FAIL pair_spacing k=%0d got %0d expected 51", k, cyc - last_cyc); end
                end
                $display("transfer k=%0d x=%0d y=%0d cyc=%0d", k, x_a, y_a, cyc);
                last_cyc = cyc;
                k++;
            end
            tick(); budget++;
        end
        checks++; if (k != 4) begin errors++; $display("FAIL first_pairs_timeout got %0d transfers expected 4", k); end
    endtask

    // start and ready during HOLD must not disturb anything.
    task automatic test_hold_start();
        logic [W-1:0] sx, sy;
        logic [CW-1:0] sc;
        int budget;
        checks++; if (valid_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL hold_state got v=%b b=%b expected 0 1", valid_a, busy_a); end
        checks++; if (count_a !== CW'(4) || x_a !== W'(3) || y_a !== '0) begin errors++; $display("FAIL hold_pair got (%0d,%0d) c=%0d expected (3,0) c=4", x_a, y_a, count_a); end
        sx = x_a; sy = y_a; sc = count_a;
        repeat (5) tick();
        start_a = 1; tick(); start_a = 0; tick();
        checks++; if (x_a !== sx || y_a !== sy || count_a !== sc || valid_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL hold_start got (%0d,%0d) c=%0d v=%b b=%b expected (%0d,%0d) c=%0d v=0 b=1", x_a, y_a, count_a, valid_a, busy_a, sx, sy, sc);
        end
        ready_a = 0;
        budget = 0;
        while (!valid_a && budget < 100) begin tick(); budget++; end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL hold_exit_timeout got v=%b expected 1", valid_a); end
        checks++; if (x_a !== W'(4) || y_a !== '0 || count_a !== CW'(4)) begin errors++; $display("FAIL after_hold got (%0d,%0d) c=%0d expected (4,0) c=4", x_a, y_a, count_a); end
        $display("test_hold_start done");
    endtask

    // ready low for 10 cycles while valid: everything holds.
    task automatic test_stall();
        logic [W-1:0] sx, sy;
        logic [CW-1:0] sc;
        sx = x_a; sy = y_a; sc = count_a;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (valid_a !== 1'b1 || x_a !== sx || y_a !== sy || count_a !== sc) begin
                errors++; $display("FAIL stall_hold i=%0d got (%0d,%0d) v=%b c=%0d expected (%0d,%0d) v=1 c=%0d", i, x_a, y_a, valid_a, count_a, sx, sy, sc);
            end
        end
        ready_a = 1; tick(); ready_a = 0;
        checks++; if (count_a !== sc + CW'(1) || valid_a !== 1'b0) begin errors++; $display("FAIL stall_release got c=%0d v=%b expected c=%0d v=0", count_a, valid_a, sc + CW'(1)); end
        $display("test_stall done");
    endtask

    // DWELL=0 full sweep: consecutive transfers, one done pulse, start in DONE ignored.
    task automatic test_back_to_back();
        int k, budget, first_cyc, dones;
        logic [W-1:0] ex, ey;
        k = 0; budget = 0; first_cyc = 0; dones = 0;
        ready_b = 1; start_b = 1; tick(); start_b = 0;
        while (dones == 0 && budget < 1000) begin
            if (valid_b && ready_b) begin
                if (k == 0) first_cyc = cyc;
                ex = W'(k % (1 << W)); ey = W'(k / (1 << W));
                checks++; if (x_b !== ex || y_b !== ey || cyc != first_cyc + k) begin
                    errors++; $display("FAIL b2b_pair k=%0d got (%0d,%0d) at +%0d expected (%0d,%0d) at +%0d", k, x_b, y_b, cyc - first_cyc, ex, ey, k);
                end
                k++;
            end
            tick(); budget++;
            if (done_b) dones++;
        end
        checks++; if (k != NPAIRS) begin errors++; $display("FAIL b2b_transfers got %0d expected %0d", k, NPAIRS); end
        checks++; if (count_b !== CW'(NPAIRS)) begin errors++; $display("FAIL b2b_count got %0d expected %0d", count_b, NPAIRS); end
        $display("b2b sweep transfers=%0d count=%0d", k, count_b);
        start_b = 1; tick(); start_b = 0;
        checks++; if (done_b !== 1'b0 || busy_b !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL done_start got d=%b b=%b v=%b expected 0 0 0", done_b, busy_b, valid_b); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_b) dones++;
            checks++; if (busy_b !== 1'b0 || count_b !== CW'(NPAIRS)) begin errors++; $display("FAIL idle_after i=%0d got b=%b c=%0d expected b=0 c=%0d", i, busy_b, count_b, NPAIRS); end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL done_pulses got %0d expected 1", dones); end
        ready_b = 0;
    endtask

    // Reset at count=37 wins over the pending transfer; restart from (0,0).
    task automatic test_mid_reset();
        int budget, dones;
        budget = 0; dones = 0;
        ready_b = 1; start_b = 1; tick(); start_b = 0;
        while (count_b != CW'(37) && budget < 100) begin tick(); budget++; end
        checks++; if (count_b !== CW'(37) || valid_b !== 1'b1) begin errors++; $display("FAIL reach_37 got c=%0d v=%b expected c=37 v=1", count_b, valid_b); end
        rst_b = 1; tick(); rst_b = 0;
        checks++; if (x_b !== '0 || y_b !== '0 || valid_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || count_b !== '0) begin
            errors++; $display("FAIL mid_reset got (%0d,%0d) v=%b b=%b d=%b c=%0d expected all 0", x_b, y_b, valid_b, busy_b, done_b, count_b);
        end
        for (int i = 0; i < 4; i++) begin tick(); if (done_b) dones++; end
        checks++; if (dones != 0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_no_done got pulses=%0d b=%b expected 0 0", dones, busy_b); end
        start_b = 1; tick(); start_b = 0;
        checks++; if (valid_b !== 1'b1 || x_b !== '0 || y_b !== '0 || count_b !== '0) begin errors++; $display("FAIL restart got (%0d,%0d) v=%b c=%0d expected (0,0) v=1 c=0", x_b, y_b, valid_b, count_b); end
        tick();
        checks++; if (count_b !== CW'(1) || x_b !== W'(1)) begin errors++; $display("FAIL restart_adv got x=%0d c=%0d expected x=1 c=1", x_b, count_b); end
        rst_b = 1; ready_b = 0; tick(); rst_b = 0;
        $display("test_mid_reset done");
    endtask

    // Full DWELL=50 sweep with random ready, scored against index order.
    task automatic test_random_sweep();
        int k, budget, dones;
        bit seen [NPAIRS];
        bit prev_stall;
        logic [W-1:0] px, py, ex, ey;
        k = 0; budget = 0; dones = 0; prev_stall = 0; px = '0; py = '0;
        foreach (seen[i]) seen[i] = 1'b0;
        rst_a = 1; start_a = 0; ready_a = 0; tick(); rst_a = 0;
        start_a = 1; tick(); start_a = 0;
        while (dones == 0 && budget < 30000) begin
            if (prev_stall) begin
                checks++; if (valid_a !== 1'b1 || x_a !== px || y_a !== py) begin
                    errors++; $display("FAIL rand_stall k=%0d got (%0d,%0d) v=%b expected (%0d,%0d) v=1", k, x_a, y_a, valid_a, px, py);
                end
            end
            ready_a = 1'($urandom_range(0, 1));
            if (valid_a && ready_a) begin
                ex = W'(k % (1 << W)); ey = W'(k / (1 << W));
                checks++; if (x_a !== ex || y_a !== ey) begin errors++; $display("FAIL rand_pair k=%0d got (%0d,%0d) expected (%0d,%0d)", k, x_a, y_a, ex, ey); end
                checks++; if (z_a !== (ex & ey)) begin errors++; $display("FAIL and_out k=%0d got %0d expected %0d", k, z_a, ex & ey); end
                checks++; if (seen[{y_a, x_a}]) begin errors++; $display("FAIL pair_unique k=%0d got repeat (%0d,%0d) expected new pair", k, x_a, y_a); end
                seen[{y_a, x_a}] = 1'b1;
                checks++; if (count_a !== CW'(k)) begin errors++; $display("FAIL rand_count k=%0d got %0d expected %0d", k, count_a, k); end
                k++;
            end
            prev_stall = valid_a && !ready_a;
            px = x_a; py = y_a;
            tick(); budget++;
            if (done_a) dones++;
        end
        checks++; if (k != NPAIRS || dones != 1) begin errors++; $display("FAIL rand_sweep got %0d transfers %0d dones expected %0d and 1", k, dones, NPAIRS); end
        checks++; if (count_a !== CW'(NPAIRS)) begin errors++; $display("FAIL rand_final_count got %0d expected %0d", count_a, NPAIRS); end
        $display("random sweep transfers=%0d cycles=%0d", k, budget);
        ready_a = 0;
        tick();
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL rand_idle got d=%b b=%b expected 0 0", done_a, busy_a); end
    endtask

    initial begin
        test_reset();
        test_first_pairs();
        test_hold_start();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
